brq_exu_multdiv_iter: RTL and testbench

Standalone iterative multiply/divide unit for the brq EXU, parametrised in datapath width and multiplier radix.
- Owns its adder, shifters and intermediate registers; no ALU sharing, no external imd_val registers.
- Uses a valid/ready request and response handshake, plus a kill input for pipeline flushes.
- Covers RV M-extension semantics: MUL, MULH[S][U], DIV[U], REM[U].

---
 rtl/brq_exu_multdiv_iter.sv | 192 +++++++++++++++++++
 tb/tb_brq_exu_multdiv_iter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/brq_exu_multdiv_iter.sv
// rtl/brq_exu_multdiv_iter.sv - iterative RV M-extension multiply/divide unit
// Purpose: self-contained multiply (radix 2^MUL_BITS, optional early-out) and
//          restoring radix-2 divide with valid/ready request/response and kill.
// Ports:   clk_i, rst_i (sync, active-high)
//          req_valid_i/req_ready_o, op_i, signed_mode_i, op_a_i, op_b_i,
//          data_ind_timing_i  - request side
//          kill_i             - abort the operation in flight
//          resp_valid_o/resp_ready_i, result_o - response side
//          busy_o             - unit is not idle
module brq_exu_multdiv_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      op_i,
  input  logic [1:0]      signed_mode_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            data_ind_timing_i,
  input  logic            kill_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int PW = XLEN + MUL_BITS;   // width of high partial + digit product
  localparam int AW = 2 * XLEN + 1;
  localparam int SW = CW + 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ABS   = 3'd1;
  localparam logic [2:0] S_MUL   = 3'd2;
  localparam logic [2:0] S_DIV   = 3'd3;
  localparam logic [2:0] S_FIXUP = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CW-1:0] N_MUL = CW'(XLEN / MUL_BITS);
  localparam logic [CW-1:0] N_DIV = CW'(XLEN);

  logic [2:0]      r_state;
  logic [1:0]      r_op;
  logic [1:0]      r_sm;
  logic            r_dit;
  logic            r_neg;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_a;       // raw a, then |a|
  logic [XLEN-1:0] r_b;       // raw b, then |b|
  logic [XLEN-1:0] r_quo;     // MUL: remaining multiplier; DIV: dividend in / quotient out
  logic [AW-1:0]   r_acc;
  logic [XLEN:0]   r_rem;
  logic [XLEN-1:0] r_result;

  logic              w_is_mul;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [PW-1:0]     w_pp;
  logic [PW-1:0]     w_sum;
  logic [XLEN+PW-1:0] w_cat;
  logic [XLEN+PW-1:0] w_shift;
  logic [XLEN+PW-1:0] w_aligned;
  logic [SW-1:0]     w_eshamt;
  logic              w_early;
  logic [AW-1:0]     w_acc_next;
  logic [XLEN+1:0]   w_trial;
  logic [XLEN+1:0]   w_diff;
  logic              w_ge;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_fix;

  assign w_is_mul = ~r_op[1];
  assign w_sa     = r_sm[0] & r_a[XLEN-1];
  assign w_sb     = r_sm[1] & r_b[XLEN-1];
  assign w_abs_a  = w_sa ? -r_a : r_a;
  assign w_abs_b  = w_sb ? -r_b : r_b;

  // Multiply step: add |a| * digit into the high half, then shift right.
  assign w_pp    = PW'(r_a) * PW'(r_quo[MUL_BITS-1:0]);
  assign w_sum   = PW'(r_acc[AW-1:XLEN]) + w_pp;
  assign w_cat   = {w_sum, r_acc[XLEN-1:0]};
  assign w_shift = w_cat >> MUL_BITS;
  // On early-out the skipped iterations would only have shifted, so apply
  // their combined shift now to land the product at its final position.
  assign w_eshamt  = SW'(r_cnt - 1'b1) * SW'(MUL_BITS);
  assign w_aligned = w_shift >> w_eshamt;
  assign w_early   = !r_dit && ((r_quo >> MUL_BITS) == '0);
  assign w_acc_next = AW'(w_early ? w_aligned : w_shift);

  // Restoring divide step; the remainder is always < |b| so the trial fits.
  assign w_trial = {1'b0, r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_trial - {2'b00, r_b};
  assign w_ge    = !w_diff[XLEN+1];

  assign w_prod_s = r_neg ? -r_acc[2*XLEN-1:0] : r_acc[2*XLEN-1:0];
  assign w_quo_s  = r_neg ? -r_quo : r_quo;
  assign w_rem_s  = r_neg ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];

  always_comb begin
    w_fix = '0;
    case (r_op)
      2'd0:    w_fix = w_prod_s[XLEN-1:0];
      2'd1:    w_fix = w_prod_s[2*XLEN-1:XLEN];
      2'd2:    w_fix = w_quo_s;
      default: w_fix = w_rem_s;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_sm     <= '0;
      r_dit    <= 1'b0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_quo    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_result <= '0;
    end else if (kill_i) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_op  <= op_i;
            r_sm  <= signed_mode_i;
            r_a   <= op_a_i;
            r_b   <= op_b_i;
            r_dit <= data_ind_timing_i;
            if (op_i[1] && (op_b_i == '0) && !data_ind_timing_i) begin
              r_result <= (op_i == 2'd2) ? '1 : op_a_i;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_ABS;
            end
          end
        end
        S_ABS: begin
          r_a   <= w_abs_a;
          r_b   <= w_abs_b;
          r_quo <= w_is_mul ? w_abs_b : w_abs_a;
          r_acc <= '0;
          r_rem <= '0;
          case (r_op)
            2'd2:    r_neg <= (w_sa ^ w_sb) && (r_b != '0);
            2'd3:    r_neg <= w_sa;
            default: r_neg <= w_sa ^ w_sb;
          endcase
          r_cnt   <= w_is_mul ? N_MUL : N_DIV;
          r_state <= w_is_mul ? S_MUL : S_DIV;
        end
        S_MUL: begin
          r_acc <= w_acc_next;
          r_quo <= r_quo >> MUL_BITS;
          r_cnt <= r_cnt - 1'b1;
          if ((r_cnt == CW'(1)) || w_early) r_state <= S_FIXUP;
        end
        S_DIV: begin
          r_rem <= w_ge ? w_diff[XLEN:0] : w_trial[XLEN:0];
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= S_FIXUP;
        end
        S_FIXUP: begin
          r_result <= w_fix;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (resp_ready_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = (r_state == S_IDLE) && !kill_i;
  assign resp_valid_o = (r_state == S_DONE);
  assign busy_o       = (r_state != S_IDLE);
  assign result_o     = r_result;

endmodule

// File: tb/tb_brq_exu_multdiv_iter.sv
// tb/tb_brq_exu_multdiv_iter.sv - self-checking bench for brq_exu_multdiv_iter
module tb_brq_exu_multdiv_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  op;
  logic [1:0]  sm;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        dit;
  logic        kill;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic        exp_armed = 1'b0;
  logic [31:0] exp_result = '0;

  always #5 clk = ~clk;

  brq_exu_multdiv_iter #(.XLEN(32), .MUL_BITS(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .signed_mode_i(sm), .op_a_i(op_a), .op_b_i(op_b),
    .data_ind_timing_i(dit), .kill_i(kill),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .result_o(result), .busy_o(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: M-extension arithmetic on signed/unsigned integer values and
  // the latency the unit must show (edges after the accept edge).
  function automatic void model(input logic [1:0] m_op, input logic [1:0] m_sm,
                                input logic [31:0] a, input logic [31:0] b, input logic m_dit,
                                output logic [31:0] r, output int lat);
    longint      va, vb, q, rm;
    logic [63:0] p;
    logic [31:0] mag;
    int          k;
    va = m_sm[0] ? longint'($signed(a)) : longint'(a);
    vb = m_sm[1] ? longint'($signed(b)) : longint'(b);
    if (!m_op[1]) begin
      p = 64'(va * vb);
      r = (m_op == 2'd0) ? p[31:0] : p[63:32];
      mag = (m_sm[1] && b[31]) ? -b : b;
      k = 1;
      while (k < 16 && (mag >> (2 * k)) != 0) k++;
      lat = m_dit ? 18 : 2 + k;
    end else if (b == 0) begin
      r = (m_op == 2'd2) ? 32'hFFFF_FFFF : a;
      lat = m_dit ? 34 : 0;
    end else begin
      q  = va / vb;
      rm = va - q * vb;
      r  = (m_op == 2'd2) ? q[31:0] : rm[31:0];
      lat = 34;
    end
  endfunction

  // Compare process: every cycle the response is valid it must match the
  // outstanding expectation; a response with nothing outstanding is an error.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (!exp_armed) chk("unexpected_resp", 32'd1, 32'd0);
      else            chk("result", result, exp_result);
    end
  end

  task automatic run_op(input logic [1:0] t_op, input logic [1:0] t_sm, input logic [31:0] a,
                        input logic [31:0] b, input logic t_dit, input int hold);
    logic [31:0] er;
    int          el;
    int          lat;
    model(t_op, t_sm, a, b, t_dit, er, el);
    @(negedge clk);
    op = t_op; sm = t_sm; op_a = a; op_b = b; dit = t_dit;
    req_valid  = 1'b1;
    exp_result = er;
    exp_armed  = 1'b1;
    #1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, el);
    repeat (hold) @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    exp_armed  = 1'b0;
    chk("idle_after_resp", {31'd0, busy}, 32'd0);
  endtask

  task automatic pin(input logic [1:0] t_op, input logic [1:0] t_sm, input logic [31:0] a,
                     input logic [31:0] b, input logic t_dit, input logic [31:0] lit_r,
                     input int lit_lat, input int hold);
    logic [31:0] r;
    int          l;
    model(t_op, t_sm, a, b, t_dit, r, l);
    chk("model_result", r, lit_r);
    chk("model_latency", l, lit_lat);
    run_op(t_op, t_sm, a, b, t_dit, hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [1:0]  r_op, r_sm;
    logic [31:0] r_a, r_b;
    rst = 1'b1; req_valid = 1'b0; op = '0; sm = '0; op_a = '0; op_b = '0;
    dit = 1'b0; kill = 1'b0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    pin(2'd0, 2'b11, -32'sd3, 32'd7, 1'b1, 32'hFFFF_FFEB, 18, 5);
    pin(2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 18, 1);
    pin(2'd0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 18, 1);
    pin(2'd1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 18, 1);
    pin(2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 34, 1);
    pin(2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 34, 1);
    pin(2'd2, 2'b11, -32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFD, 34, 1);
    pin(2'd3, 2'b11, -32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFF, 34, 1);
    pin(2'd2, 2'b00, 32'd100, 32'd7, 1'b1, 32'd14, 34, 1);
    pin(2'd3, 2'b00, 32'd100, 32'd7, 1'b1, 32'd2, 34, 1);
    pin(2'd2, 2'b11, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 0, 2);
    pin(2'd3, 2'b11, -32'sd7, 32'd0, 1'b0, 32'hFFFF_FFF9, 0, 2);
    pin(2'd2, 2'b11, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 34, 1);
    pin(2'd3, 2'b11, -32'sd7, 32'd0, 1'b1, 32'hFFFF_FFF9, 34, 1);
    pin(2'd0, 2'b00, 32'd1234, 32'd3, 1'b0, 32'd3702, 3, 1);
    pin(2'd0, 2'b00, 32'd1234, 32'd3, 1'b1, 32'd3702, 18, 1);

    // Kill during the 10th divide iteration: no response may follow.
    @(negedge clk);
    op = 2'd2; sm = 2'b00; op_a = 32'd1000; op_b = 32'd3; dit = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    #1;
    chk("kill_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("kill_req_ready", {31'd0, req_ready}, 32'd1);
    chk("kill_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    run_op(2'd0, 2'b00, 32'd6, 32'd7, 1'b1, 1);
    chk("mul_after_kill", result, 32'd42);

    // Reset in the middle of a multiply.
    @(negedge clk);
    op = 2'd0; sm = 2'b11; op_a = 32'h1234_5678; op_b = 32'h8765_4321; dit = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Kill together with a request in IDLE blocks the accept.
    @(negedge clk);
    op = 2'd0; op_a = 32'd3; op_b = 32'd4; req_valid = 1'b1; kill = 1'b1;
    #1;
    chk("kill_idle_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0;
    #1;
    chk("kill_idle_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 80; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_sm = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      case ($urandom_range(0, 4))
        0:       r_b = 32'($urandom_range(0, 15));
        1:       r_b = 32'd0;
        2:       r_b = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
        3:       r_b = 32'($urandom_range(0, 65535));
        default: r_b = $urandom;
      endcase
      run_op(r_op, r_sm, r_a, r_b, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
